// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode, plus status.
// master = fetch/decode/branch side that drives the queue, slave = the queue itself.
interface fetch_decode_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [15:0]      in_instr;
  logic [15:0]      in_pcnext;
  logic             in_ready;
  logic             out_valid;
  logic [15:0]      out_instr;
  logic [15:0]      out_pcnext;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             halt_pending;

  modport master (
    output in_valid, in_instr, in_pcnext, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pcnext, count, halt_pending
  );

  modport slave (
    input  in_valid, in_instr, in_pcnext, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pcnext, count, halt_pending
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular prefetch queue between fetch and decode, squashed by flush, frozen after a HALT.
// Define FDQ_BYPASS_EN to let an instruction pass straight through an empty queue.
module fetch_decode_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input logic                  clk,
  input logic                  rst,
  fetch_decode_queue_if.slave  fdq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_reg;
  logic             halt_pending_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [15:0] instr_mem  [DEPTH];
  logic [15:0] pcnext_mem [DEPTH];

  logic in_ready_c;
  logic push;
  logic push_store;
  logic pop_mem;
  logic bypass;
  logic is_halt;

  assign in_ready_c = (count_reg < CNT_W'(DEPTH)) && (state_reg == RUN) && !fdq.flush;
  assign push       = fdq.in_valid && in_ready_c;
  assign pop_mem    = (count_reg != '0) && fdq.out_ready;
  assign is_halt    = (fdq.in_instr[15:11] == HALT_OPC);

`ifdef FDQ_BYPASS_EN
  assign bypass = (count_reg == '0) && fdq.in_valid && (state_reg == RUN) && !fdq.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that decode takes the same cycle never lands in storage.
  assign push_store = push && !(bypass && fdq.out_ready);

  always_comb begin
    count_next = count_reg;
    case ({push_store, pop_mem})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately left unreset; only the pointers and count track validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_store && (wr_ptr_reg == PTR_W'(gi))) begin
        instr_mem[gi]  <= fdq.in_instr;
        pcnext_mem[gi] <= fdq.in_pcnext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fdq.flush) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      state_reg        <= RUN;
      halt_pending_reg <= 1'b0;
    end else begin
      if (push_store) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_mem)    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      case (state_reg)
        RUN: begin
          if (push && is_halt) begin
            state_reg        <= HALTED;
            halt_pending_reg <= 1'b1;
          end
        end
        HALTED: begin
          state_reg        <= HALTED;
          halt_pending_reg <= 1'b1;
        end
        default: begin
          state_reg        <= RUN;
          halt_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fdq.out_valid  = 1'b0;
    fdq.out_instr  = NOP_INSTR;
    fdq.out_pcnext = 16'h0000;
    if (count_reg != '0) begin
      fdq.out_valid  = 1'b1;
      fdq.out_instr  = instr_mem[rd_ptr_reg];
      fdq.out_pcnext = pcnext_mem[rd_ptr_reg];
    end else if (bypass) begin
      fdq.out_valid  = 1'b1;
      fdq.out_instr  = fdq.in_instr;
      fdq.out_pcnext = fdq.in_pcnext;
    end
  end

  assign fdq.in_ready     = in_ready_c;
  assign fdq.count        = count_reg;
  assign fdq.halt_pending = halt_pending_reg;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised and directed bench for fetch_decode_queue against a queue-based reference model.
// Expectations follow FDQ_BYPASS_EN when the bench is built with it.
module tb_fetch_decode_queue;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] NOP      = 16'h0800;
  localparam logic [4:0]  HALT_OPC = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_decode_queue_if #(.DEPTH(DEPTH)) fdq ();

  fetch_decode_queue #(
    .DEPTH(DEPTH), .NOP_INSTR(NOP), .HALT_OPC(HALT_OPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fdq(fdq)
  );

  // Reference model: a plain queue of {instr, pcnext} plus a halted flag.
  logic [31:0] mq[$];
  bit          m_halted;
  logic        e_in_ready, e_out_valid, e_bypass, e_halt;
  logic [15:0] e_out_instr, e_out_pcnext;
  logic [2:0]  e_count;

  function automatic logic [37:0] obs_vec();
    return {fdq.out_valid, fdq.out_instr, fdq.out_pcnext, fdq.in_ready, fdq.count, fdq.halt_pending};
  endfunction

  function automatic logic [37:0] exp_vec();
    return {e_out_valid, e_out_instr, e_out_pcnext, e_in_ready, e_count, e_halt};
  endfunction

  task automatic model_expect();
    bit byp;
    byp = 1'b0;
`ifdef FDQ_BYPASS_EN
    byp = (mq.size() == 0) && fdq.in_valid && !m_halted && !fdq.flush;
`endif
    e_bypass   = byp;
    e_in_ready = (mq.size() < DEPTH) && !m_halted && !fdq.flush;
    e_count    = 3'(mq.size());
    e_halt     = m_halted;
    if (mq.size() != 0) begin
      e_out_valid = 1'b1; e_out_instr = mq[0][31:16]; e_out_pcnext = mq[0][15:0];
    end else if (byp) begin
      e_out_valid = 1'b1; e_out_instr = fdq.in_instr; e_out_pcnext = fdq.in_pcnext;
    end else begin
      e_out_valid = 1'b0; e_out_instr = NOP; e_out_pcnext = 16'h0000;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then step the clock.
  task automatic model_commit();
    bit acc;
    if (rst || fdq.flush) begin
      mq.delete();
      m_halted = 1'b0;
    end else begin
      acc = fdq.in_valid && e_in_ready;
      if (fdq.out_ready && mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        if (!(e_bypass && fdq.out_ready)) mq.push_back({fdq.in_instr, fdq.in_pcnext});
        if (fdq.in_instr[15:11] == HALT_OPC) m_halted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                       input bit ordy, input bit fl);
    fdq.in_valid  = v;
    fdq.in_instr  = ins;
    fdq.in_pcnext = pc;
    fdq.out_ready = ordy;
    fdq.flush     = fl;
    #1;
    model_expect();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 0, 0);
    model_commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (obs_vec() !== {1'b0, NOP, 16'h0000, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs_vec(), {1'b0, NOP, 16'h0000, 1'b1, 3'd0, 1'b0});
    end
    drive(1, 16'h9001, 16'h0010, 0, 0); model_commit();
    drive(1, 16'h9002, 16'h0012, 0, 0); model_commit();
    do_reset();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.count !== 3'd0 || fdq.out_valid !== 1'b0 || fdq.out_instr !== NOP) begin
      errors++;
      $display("FAIL reset_midop count=%0d out_valid=%b out_instr=%h want 0/0/%h",
               fdq.count, fdq.out_valid, fdq.out_instr, NOP);
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 16'hA001, 16'h0002, 0, 0);
    model_commit();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.out_valid !== 1'b1 || fdq.out_instr !== 16'hA001 || fdq.out_pcnext !== 16'h0002 ||
        fdq.count !== 3'd1 || fdq.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_push valid=%b instr=%h pc=%h count=%0d in_ready=%b want 1/a001/0002/1/1",
               fdq.out_valid, fdq.out_instr, fdq.out_pcnext, fdq.count, fdq.in_ready);
    end
  endtask

  task automatic test_full();
    logic [15:0] ins[5];
    do_reset();
    for (int i = 0; i < 5; i++) ins[i] = 16'h8000 | 16'($urandom_range(0, 32767));
    for (int i = 0; i < 4; i++) begin
      drive(1, ins[i], 16'(2 * i + 2), 0, 0);
      model_commit();
    end
    drive(1, ins[4], 16'h00AA, 1, 0);
    checks++;
    if (fdq.count !== 3'd4 || fdq.in_ready !== 1'b0 || fdq.out_instr !== ins[0]) begin
      errors++;
      $display("FAIL full_state count=%0d in_ready=%b head=%h want 4/0/%h",
               fdq.count, fdq.in_ready, fdq.out_instr, ins[0]);
    end
    model_commit();
    for (int i = 1; i < 4; i++) begin
      drive(0, 16'h0, 16'h0, 1, 0);
      checks++;
      if (fdq.out_valid !== 1'b1 || fdq.out_instr !== ins[i] || fdq.count !== 3'(4 - i)) begin
        errors++;
        $display("FAIL full_drain%0d valid=%b instr=%h count=%0d want 1/%h/%0d",
                 i, fdq.out_valid, fdq.out_instr, fdq.count, ins[i], 4 - i);
      end
      model_commit();
    end
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.out_valid !== 1'b0 || fdq.count !== 3'd0) begin
      errors++;
      $display("FAIL full_fifth_absent valid=%b count=%0d want 0/0", fdq.out_valid, fdq.count);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hC000 | 16'(i), 16'(i * 2), 0, 0);
      model_commit();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1, 16'h8000 | 16'($urandom_range(0, 32767)), 16'($urandom), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec() || fdq.count !== 3'd3) begin
        errors++;
        $display("FAIL stream cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      model_commit();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hD000 | 16'(i), 16'(i * 2), 0, 0);
      model_commit();
    end
    drive(1, 16'hE123, 16'h4444, 1, 1);
    checks++;
    if (fdq.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready got=%b want 0", fdq.in_ready);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (obs_vec() !== {1'b0, NOP, 16'h0000, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush_empty got=%h want=%h", obs_vec(), {1'b0, NOP, 16'h0000, 1'b1, 3'd0, 1'b0});
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 16'h1234, 16'h0100, 0, 0); model_commit();
    drive(1, 16'h0000, 16'h0102, 0, 0); model_commit();
    drive(1, 16'h5678, 16'h0104, 0, 0);
    checks++;
    if (fdq.halt_pending !== 1'b1 || fdq.in_ready !== 1'b0 || fdq.count !== 3'd2) begin
      errors++;
      $display("FAIL halt_block halt=%b in_ready=%b count=%0d want 1/0/2",
               fdq.halt_pending, fdq.in_ready, fdq.count);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 1, 0);
    checks++;
    if (fdq.out_instr !== 16'h1234 || fdq.count !== 3'd2) begin
      errors++;
      $display("FAIL halt_first instr=%h count=%0d want 1234/2", fdq.out_instr, fdq.count);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 1, 0);
    checks++;
    if (fdq.out_valid !== 1'b1 || fdq.out_instr !== 16'h0000 || fdq.out_pcnext !== 16'h0102) begin
      errors++;
      $display("FAIL halt_second valid=%b instr=%h pc=%h want 1/0000/0102",
               fdq.out_valid, fdq.out_instr, fdq.out_pcnext);
    end
    model_commit();
    drive(1, 16'h5678, 16'h0104, 0, 0);
    checks++;
    if (fdq.out_valid !== 1'b0 || fdq.halt_pending !== 1'b1 || fdq.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_drained valid=%b halt=%b in_ready=%b want 0/1/0",
               fdq.out_valid, fdq.halt_pending, fdq.in_ready);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 0, 1); model_commit();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.in_ready !== 1'b1 || fdq.halt_pending !== 1'b0) begin
      errors++;
      $display("FAIL halt_flush in_ready=%b halt=%b want 1/0", fdq.in_ready, fdq.halt_pending);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1, 16'hBEEF, 16'h0222, 1, 0);
`ifdef FDQ_BYPASS_EN
    checks++;
    if (fdq.out_valid !== 1'b1 || fdq.out_instr !== 16'hBEEF || fdq.out_pcnext !== 16'h0222) begin
      errors++;
      $display("FAIL bypass_same valid=%b instr=%h pc=%h want 1/beef/0222",
               fdq.out_valid, fdq.out_instr, fdq.out_pcnext);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.count !== 3'd0 || fdq.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_consumed count=%0d valid=%b want 0/0", fdq.count, fdq.out_valid);
    end
`else
    checks++;
    if (fdq.out_valid !== 1'b0 || fdq.out_instr !== NOP) begin
      errors++;
      $display("FAIL nobypass_same valid=%b instr=%h want 0/%h", fdq.out_valid, fdq.out_instr, NOP);
    end
    model_commit();
    drive(0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (fdq.out_valid !== 1'b1 || fdq.out_instr !== 16'hBEEF || fdq.count !== 3'd1) begin
      errors++;
      $display("FAIL nobypass_next valid=%b instr=%h count=%0d want 1/beef/1",
               fdq.out_valid, fdq.out_instr, fdq.count);
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] ins;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ins[15:11] = HALT_OPC;
      else if (ins[15:11] == HALT_OPC) ins[15] = 1'b1;
      drive($urandom_range(0, 9) < 7, ins, 16'($urandom), $urandom_range(0, 9) < 5,
            $urandom_range(0, 19) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      model_commit();
    end
  endtask

  initial begin
    fdq.in_valid = 1'b0; fdq.in_instr = '0; fdq.in_pcnext = '0;
    fdq.out_ready = 1'b0; fdq.flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_flush();
    test_halt();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
